// File: rtl/sclkfiforead.sv
// Read-side adapter: drains a single-clock FIFO (1-cycle read latency) into a valid/ready stream.
// Optional accepted-word counter port out_count is enabled by defining SCLKFIFOREAD_COUNT_EN.
module sclkfiforead #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             arst,
  output logic             ren,
  input  logic [WIDTH-1:0] rdata,
  input  logic             rempty,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef SCLKFIFOREAD_COUNT_EN
  ,
  output logic [15:0]      out_count
`endif
);

  logic [1:0]       occ_q, occ_d;
  logic             pend_q, pend_d;
  logic [1:0]       head_q, head_d;
  logic [1:0]       tail_q, tail_d;
  logic [WIDTH-1:0] buf_q [3];
  logic             cap, pop;

  function automatic logic [1:0] wrap_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Issue is gated on registered state only, so out_ready never reaches ren.
  assign ren       = !arst && !rempty && (({1'b0, occ_q} + {2'b00, pend_q}) < 3'd3);
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = buf_q[head_q];
  assign cap       = pend_q;
  assign pop       = out_valid && out_ready;

  always_comb begin
    occ_d  = occ_q;
    pend_d = ren;
    head_d = head_q;
    tail_d = tail_q;
    if (cap) tail_d = wrap_inc(tail_q);
    if (pop) head_d = wrap_inc(head_q);
    case ({cap, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      occ_q  <= '0;
      pend_q <= 1'b0;
      head_q <= '0;
      tail_q <= '0;
      for (int unsigned i = 0; i < 3; i++) buf_q[i] <= '0;
    end else begin
      occ_q  <= occ_d;
      pend_q <= pend_d;
      head_q <= head_d;
      tail_q <= tail_d;
      if (cap) buf_q[tail_q] <= rdata;
    end
  end

`ifdef SCLKFIFOREAD_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (pop) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign out_count = cnt_q;
`endif

endmodule

// File: tb/tb_sclkfiforead.sv
// Randomized bench for sclkfiforead against a counting model of reads issued, words captured and words popped.
// Define SCLKFIFOREAD_COUNT_EN to also exercise the out_count port and its wrap.
module tb_sclkfiforead;

  logic        clk = 1'b0;
  logic        arst;
  logic        ren;
  logic [31:0] rdata;
  logic        rempty;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef SCLKFIFOREAD_COUNT_EN
  logic [15:0] out_count;
`endif

  int total_chk = 0;
  int bad_chk   = 0;

  // Model: word k (0-based) supplied by the FIFO has value k+1.
  int issued, captured, popped, total;
  bit pend_m;
  int cnt_m;
  int cyc, first_valid, last_pop, ren_pulses;

  always #5 clk = ~clk;

  sclkfiforead #(.WIDTH(32)) dut (
    .clk       (clk),
    .arst      (arst),
    .ren       (ren),
    .rdata     (rdata),
    .rempty    (rempty),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SCLKFIFOREAD_COUNT_EN
    ,
    .out_count (out_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_chk++;
    if (got !== exp) begin
      bad_chk++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    issued = 0; captured = 0; popped = 0; total = 0;
    pend_m = 1'b0; cnt_m = 0;
    cyc = 0; first_valid = -1; last_pop = -1; ren_pulses = 0;
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic step(input int gap_pct, input int rdy_pct);
    bit rd, pp;
    rempty    = (issued >= total) || (int'($urandom_range(99)) < gap_pct);
    out_ready = int'($urandom_range(99)) < rdy_pct;
    #1;
    check("ren", ren, !rempty && ((issued - popped) < 3));
    check("out_valid", out_valid, (captured - popped) > 0);
    if (captured > popped) check("out_data", out_data, popped + 1);
`ifdef SCLKFIFOREAD_COUNT_EN
    check("out_count", out_count, cnt_m[15:0]);
`endif
    rd = ren && !rempty;
    pp = out_valid && out_ready;
    if (rd) ren_pulses++;
    if (out_valid && first_valid < 0) first_valid = cyc;
    if (pp) last_pop = cyc;
    @(posedge clk);
    if (pend_m) captured++;
    pend_m = rd;
    if (rd) issued++;
    if (pp) begin popped++; cnt_m++; end
    cyc++;
    #1 rdata = rd ? issued : $urandom;
    @(negedge clk);
  endtask

  task automatic run_words(input int n, input int gap_pct, input int rdy_pct);
    int lim;
    total += n;
    lim = (total - popped) * 30 + 100;
    while (popped < total && lim > 0) begin
      step(gap_pct, rdy_pct);
      lim--;
    end
    if (popped < total) check("drain_timeout", popped, total);
  endtask

  task automatic do_reset();
    arst = 1'b1; rempty = 1'b0; out_ready = 1'b0; rdata = '0;
    model_clear();
    repeat (3) begin
      #1;
      check("rst_ren", ren, 0);
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
`ifdef SCLKFIFOREAD_COUNT_EN
      check("rst_count", out_count, 0);
`endif
      @(negedge clk);
    end
    arst = 1'b0;
  endtask

  initial begin
    int lim;
    arst = 1'b1; rempty = 1'b1; out_ready = 1'b0; rdata = '0;
    model_clear();
    @(negedge clk);

    // Reset, then streaming 1..128 with no bubbles after the fill latency.
    do_reset();
    run_words(128, 0, 100);
    check("fill_latency", first_valid, 2);
    check("stream_no_gaps", last_pop - first_valid, 127);

    // Backpressure: exactly three reads, head held at word 1.
    do_reset();
    total = 20;
    repeat (10) step(0, 0);
    check("bp_ren_pulses", ren_pulses, 3);
    check("bp_valid", out_valid, 1);
    check("bp_head", out_data, 1);
    run_words(0, 0, 100);

    // Random gaps and backpressure.
    do_reset();
    run_words(1000, 30, 50);

    // Asynchronous reset with two words held and one read in flight.
    do_reset();
    total = 10;
    lim = 20;
    while (!((captured - popped) == 2 && pend_m) && lim > 0) begin
      step(0, 0);
      lim--;
    end
    check("mid_state_reached", lim > 0, 1);
    #2 arst = 1'b1;
    #1;
    check("async_valid", out_valid, 0);
    check("async_ren", ren, 0);
    check("async_data", out_data, 0);
`ifdef SCLKFIFOREAD_COUNT_EN
    check("async_count", out_count, 0);
`endif
    @(negedge clk);
    model_clear();
    rdata = '0;
    arst = 1'b0;
    run_words(5, 0, 100);
    check("post_rst_popped", popped, 5);

`ifdef SCLKFIFOREAD_COUNT_EN
    do_reset();
    run_words(65537, 0, 100);
    #1 check("count_wrap", out_count, 1);
    @(negedge clk);
`endif

    $display("test done: total=%0d bad=%0d", total_chk, bad_chk);
    $finish;
  end

endmodule
